// File: rtl/parking_gate_controller_if.sv
// Request/gate/occupancy bundle between the car-park field side and the gate controller.
// The master drives requests and the car detector; the slave is the controller.
interface parking_gate_controller_if #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3
);
  logic                 entry_req;
  logic                 exit_req;
  logic [SLOT_W-1:0]    exit_slot;
  logic                 car_present;
  logic                 entry_gate_open;
  logic                 exit_gate_open;
  logic                 grant_valid;
  logic [SLOT_W-1:0]    grant_slot;
  logic                 entry_denied;
  logic                 exit_error;
  logic [NUM_SLOTS-1:0] parking_capacity;
  logic [SLOT_W:0]      free_count;
  logic                 full;

  modport master (
    output entry_req, exit_req, exit_slot, car_present,
    input  entry_gate_open, exit_gate_open, grant_valid, grant_slot,
           entry_denied, exit_error, parking_capacity, free_count, full
  );

  modport slave (
    input  entry_req, exit_req, exit_slot, car_present,
    output entry_gate_open, exit_gate_open, grant_valid, grant_slot,
           entry_denied, exit_error, parking_capacity, free_count, full
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier sequencer that owns the slot-occupancy mask, arbitrates
// buffered requests and times each gate-open interval.
module parking_gate_controller #(
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_W      = 3,
  parameter int GATE_CYCLES = 16
) (
  input logic                       clk,
  input logic                       rst,
  parking_gate_controller_if.slave  bus
);

  localparam int TIMER_W = $clog2(GATE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN,
    HOLD_ENTRY,
    HOLD_EXIT
  } state_t;

  state_t               state, state_next;
  logic                 entry_q, exit_q;
  logic                 pend_entry, pend_entry_next;
  logic                 pend_exit, pend_exit_next;
  logic [SLOT_W-1:0]    exit_slot_q, exit_slot_q_next;
  logic                 prio_exit, prio_exit_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [NUM_SLOTS-1:0] capacity, capacity_next;
  logic [SLOT_W:0]      free_count_r, free_count_next;
  logic                 full_r, full_next;
  logic [SLOT_W-1:0]    grant_slot_r, grant_slot_next;
  logic                 grant_valid_r, grant_valid_next;
  logic                 entry_denied_r, entry_denied_next;
  logic                 exit_error_r, exit_error_next;
  logic                 entry_gate_r, entry_gate_next;
  logic                 exit_gate_r, exit_gate_next;

  logic                 entry_rise, exit_rise;
  logic                 serve_entry, serve_exit;
  logic                 clr_entry, clr_exit;
  logic                 slot_out_of_range;
  logic [SLOT_W-1:0]    lowest_free;

  // Next-state, request bookkeeping and occupancy update.
  always_comb begin
    state_next        = state;
    pend_entry_next   = pend_entry;
    pend_exit_next    = pend_exit;
    exit_slot_q_next  = exit_slot_q;
    prio_exit_next    = prio_exit;
    timer_next        = timer;
    capacity_next     = capacity;
    grant_slot_next   = grant_slot_r;
    grant_valid_next  = 1'b0;
    entry_denied_next = 1'b0;
    exit_error_next   = 1'b0;
    clr_entry         = 1'b0;
    clr_exit          = 1'b0;
    serve_entry       = 1'b0;
    serve_exit        = 1'b0;
    free_count_next   = '0;

    entry_rise = bus.entry_req & ~entry_q;
    exit_rise  = bus.exit_req & ~exit_q;
    slot_out_of_range = ({1'b0, exit_slot_q} >= (SLOT_W+1)'(NUM_SLOTS));

    lowest_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (capacity[i]) lowest_free = SLOT_W'(i);
    end

    case (state)
      IDLE: begin
        // Exit wins when full (it is the only request that can make progress).
        serve_exit  = pend_exit & (~pend_entry | full_r | prio_exit);
        serve_entry = pend_entry & ~serve_exit;
        if (serve_exit) begin
          clr_exit       = 1'b1;
          prio_exit_next = 1'b0;
          if (slot_out_of_range || capacity[exit_slot_q]) begin
            exit_error_next = 1'b1;
          end else begin
            capacity_next[exit_slot_q] = 1'b1;
            timer_next = TIMER_W'(GATE_CYCLES - 1);
            state_next = EXIT_OPEN;
          end
        end else if (serve_entry) begin
          clr_entry      = 1'b1;
          prio_exit_next = 1'b1;
          if (full_r) begin
            entry_denied_next = 1'b1;
          end else begin
            capacity_next[lowest_free] = 1'b0;
            grant_slot_next  = lowest_free;
            grant_valid_next = 1'b1;
            timer_next = TIMER_W'(GATE_CYCLES - 1);
            state_next = ENTRY_OPEN;
          end
        end
      end
      ENTRY_OPEN: begin
        if (timer == '0) state_next = bus.car_present ? HOLD_ENTRY : IDLE;
        else             timer_next = timer - 1'b1;
      end
      EXIT_OPEN: begin
        if (timer == '0) state_next = bus.car_present ? HOLD_EXIT : IDLE;
        else             timer_next = timer - 1'b1;
      end
      HOLD_ENTRY: if (!bus.car_present) state_next = IDLE;
      HOLD_EXIT:  if (!bus.car_present) state_next = IDLE;
      default:    state_next = IDLE;
    endcase

    // A rising edge that arrives while its flag is still pending is dropped.
    pend_entry_next = clr_entry ? 1'b0 : (pend_entry | entry_rise);
    pend_exit_next  = clr_exit  ? 1'b0 : (pend_exit | exit_rise);
    if (exit_rise && !pend_exit) exit_slot_q_next = bus.exit_slot;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_count_next = free_count_next + (SLOT_W+1)'(capacity_next[i]);
    end
    full_next = (free_count_next == '0);

    entry_gate_next = (state_next == ENTRY_OPEN) || (state_next == HOLD_ENTRY);
    exit_gate_next  = (state_next == EXIT_OPEN)  || (state_next == HOLD_EXIT);
  end

  // State register; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      entry_q        <= 1'b0;
      exit_q         <= 1'b0;
      pend_entry     <= 1'b0;
      pend_exit      <= 1'b0;
      exit_slot_q    <= '0;
      prio_exit      <= 1'b1;
      timer          <= '0;
      capacity       <= '1;
      free_count_r   <= (SLOT_W+1)'(NUM_SLOTS);
      full_r         <= 1'b0;
      grant_slot_r   <= '0;
      grant_valid_r  <= 1'b0;
      entry_denied_r <= 1'b0;
      exit_error_r   <= 1'b0;
      entry_gate_r   <= 1'b0;
      exit_gate_r    <= 1'b0;
    end else begin
      state          <= state_next;
      entry_q        <= bus.entry_req;
      exit_q         <= bus.exit_req;
      pend_entry     <= pend_entry_next;
      pend_exit      <= pend_exit_next;
      exit_slot_q    <= exit_slot_q_next;
      prio_exit      <= prio_exit_next;
      timer          <= timer_next;
      capacity       <= capacity_next;
      free_count_r   <= free_count_next;
      full_r         <= full_next;
      grant_slot_r   <= grant_slot_next;
      grant_valid_r  <= grant_valid_next;
      entry_denied_r <= entry_denied_next;
      exit_error_r   <= exit_error_next;
      entry_gate_r   <= entry_gate_next;
      exit_gate_r    <= exit_gate_next;
    end
  end

  assign bus.entry_gate_open  = entry_gate_r;
  assign bus.exit_gate_open   = exit_gate_r;
  assign bus.grant_valid      = grant_valid_r;
  assign bus.grant_slot       = grant_slot_r;
  assign bus.entry_denied     = entry_denied_r;
  assign bus.exit_error       = exit_error_r;
  assign bus.parking_capacity = capacity;
  assign bus.free_count       = free_count_r;
  assign bus.full             = full_r;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a gate/occupancy reference model kept in the bench.
module tb_parking_gate_controller;

  localparam int GATE_CYCLES = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_gate_controller_if #(.NUM_SLOTS(8), .SLOT_W(3)) bus ();

  parking_gate_controller #(.NUM_SLOTS(8), .SLOT_W(3), .GATE_CYCLES(GATE_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: which gate is up (0 none, 1 entry, 2 exit) and for how long.
  logic [7:0] m_cap;
  logic [2:0] m_slot_q, m_grant_slot;
  bit         m_prev_e, m_prev_x, m_pend_e, m_pend_x, m_prio_exit;
  bit         m_grant, m_denied, m_error;
  int         m_gate, m_elapsed;

  // Window observations for directed scenarios.
  int w_grant_slot, w_entry_cycles, w_exit_cycles, w_first_gate;
  int w_grant_cyc, w_err_cyc, w_overlap;
  bit w_denied, w_error;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic model_reset();
    m_cap = 8'hFF; m_slot_q = '0; m_grant_slot = '0;
    m_prev_e = 0; m_prev_x = 0; m_pend_e = 0; m_pend_x = 0; m_prio_exit = 1;
    m_grant = 0; m_denied = 0; m_error = 0; m_gate = 0; m_elapsed = 0;
  endtask

  // Advances the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    bit rise_e, rise_x, pick_exit, served_e, served_x;
    if (rst) begin
      model_reset();
      return;
    end
    rise_e = bus.entry_req && !m_prev_e;
    rise_x = bus.exit_req && !m_prev_x;
    served_e = 0; served_x = 0;
    m_grant = 0; m_denied = 0; m_error = 0;
    if (m_gate == 0) begin
      if (m_pend_e && m_pend_x) pick_exit = (m_cap == 0) || m_prio_exit;
      else                      pick_exit = m_pend_x;
      if (pick_exit) begin
        served_x = 1; m_prio_exit = 0;
        if (m_cap[m_slot_q]) m_error = 1;
        else begin m_cap[m_slot_q] = 1'b1; m_gate = 2; m_elapsed = 1; end
      end else if (m_pend_e) begin
        served_e = 1; m_prio_exit = 1;
        if (m_cap == 0) m_denied = 1;
        else begin
          for (int i = 7; i >= 0; i--) if (m_cap[i]) m_grant_slot = 3'(i);
          m_cap[m_grant_slot] = 1'b0;
          m_grant = 1; m_gate = 1; m_elapsed = 1;
        end
      end
    end else begin
      if (m_elapsed >= GATE_CYCLES && !bus.car_present) m_gate = 0;
      else m_elapsed++;
    end
    if (served_e) m_pend_e = 0;
    else if (rise_e) m_pend_e = 1;
    if (served_x) m_pend_x = 0;
    else if (rise_x && !m_pend_x) begin m_pend_x = 1; m_slot_q = bus.exit_slot; end
    m_prev_e = bus.entry_req;
    m_prev_x = bus.exit_req;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cycle++;
    checkOutput("entry_gate_open", bus.entry_gate_open, m_gate == 1);
    checkOutput("exit_gate_open", bus.exit_gate_open, m_gate == 2);
    checkOutput("gates_exclusive", bus.entry_gate_open & bus.exit_gate_open, 0);
    checkOutput("grant_valid", bus.grant_valid, m_grant);
    checkOutput("grant_slot", bus.grant_slot, m_grant_slot);
    checkOutput("entry_denied", bus.entry_denied, m_denied);
    checkOutput("exit_error", bus.exit_error, m_error);
    checkOutput("parking_capacity", bus.parking_capacity, m_cap);
    checkOutput("free_count", bus.free_count, $countones(m_cap));
    checkOutput("full", bus.full, m_cap == 0);
  endtask

  task automatic applyStimulus(input bit e, input bit x, input logic [2:0] s, input bit car, input int n);
    bus.entry_req = e; bus.exit_req = x; bus.exit_slot = s; bus.car_present = car;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 2);
    rst = 1'b0;
  endtask

  task automatic observe();
    if (bus.grant_valid) begin w_grant_slot = bus.grant_slot; w_grant_cyc = cycle; end
    if (bus.entry_denied) w_denied = 1;
    if (bus.exit_error) begin w_error = 1; w_err_cyc = cycle; end
    if (bus.entry_gate_open) begin w_entry_cycles++; if (w_first_gate == 0) w_first_gate = 1; end
    if (bus.exit_gate_open) begin w_exit_cycles++; if (w_first_gate == 0) w_first_gate = 2; end
    if (bus.entry_gate_open && bus.exit_gate_open) w_overlap++;
  endtask

  // One cycle of request edges, then n quiet cycles, collecting what happened.
  task automatic service(input bit e, input bit x, input logic [2:0] s, input int n);
    w_grant_slot = -1; w_entry_cycles = 0; w_exit_cycles = 0; w_first_gate = 0;
    w_grant_cyc = -1; w_err_cyc = -1; w_overlap = 0; w_denied = 0; w_error = 0;
    applyStimulus(e, x, s, 0, 1);
    observe();
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, s, 0, 1);
      observe();
    end
  endtask

  initial begin
    int hold_cycles;
    rst = 1'b0;
    bus.entry_req = 0; bus.exit_req = 0; bus.exit_slot = 0; bus.car_present = 0;
    model_reset();
    do_reset();

    checkOutput("reset_capacity", bus.parking_capacity, 8'hFF);
    checkOutput("reset_free_count", bus.free_count, 8);
    checkOutput("reset_full", bus.full, 0);
    checkOutput("reset_grant_slot", bus.grant_slot, 0);

    service(1, 0, 0, 24);
    checkOutput("first_grant_slot", w_grant_slot, 0);
    checkOutput("first_entry_open_cycles", w_entry_cycles, 16);
    checkOutput("first_capacity", bus.parking_capacity, 8'hFE);
    checkOutput("first_free_count", bus.free_count, 7);

    for (int i = 1; i < 8; i++) begin
      service(1, 0, 0, 24);
      checkOutput("fill_grant_slot", w_grant_slot, i);
    end
    checkOutput("fill_capacity", bus.parking_capacity, 8'h00);
    checkOutput("fill_full", bus.full, 1);
    service(1, 0, 0, 24);
    checkOutput("ninth_denied", w_denied, 1);
    checkOutput("ninth_no_gate", w_entry_cycles, 0);

    service(0, 1, 3, 24);
    checkOutput("exit3_capacity", bus.parking_capacity, 8'h08);
    checkOutput("exit3_open_cycles", w_exit_cycles, 16);
    service(1, 0, 0, 24);
    checkOutput("reuse_slot3", w_grant_slot, 3);

    service(0, 1, 5, 24);
    checkOutput("exit5_capacity", bus.parking_capacity, 8'h20);
    service(0, 1, 5, 24);
    checkOutput("exit5_again_error", w_error, 1);
    checkOutput("exit5_again_capacity", bus.parking_capacity, 8'h20);
    checkOutput("exit5_again_no_gate", w_exit_cycles, 0);

    service(1, 0, 0, 24);
    checkOutput("refill_slot5", w_grant_slot, 5);
    service(1, 1, 2, 44);
    checkOutput("full_both_exit_first", w_first_gate, 2);
    checkOutput("full_both_grant", w_grant_slot, 2);
    checkOutput("full_both_no_overlap", w_overlap, 0);

    do_reset();
    service(1, 1, 0, 44);
    checkOutput("rr_exit_served_first", (w_err_cyc >= 0) && (w_err_cyc < w_grant_cyc), 1);
    checkOutput("rr_entry_grant", w_grant_slot, 0);
    service(1, 1, 0, 44);
    checkOutput("rr_exit_gate_first", w_first_gate, 2);
    checkOutput("rr_no_overlap", w_overlap, 0);

    do_reset();
    hold_cycles = 0;
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      if (bus.entry_gate_open) hold_cycles++;
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 1);
      if (bus.entry_gate_open) hold_cycles++;
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      if (bus.entry_gate_open) hold_cycles++;
    end
    checkOutput("hold_open_cycles", hold_cycles, GATE_CYCLES + 5);

    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 4);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pre_reset_gate", bus.entry_gate_open, 1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    rst = 1'b0;
    checkOutput("midreset_gate", bus.entry_gate_open, 0);
    checkOutput("midreset_capacity", bus.parking_capacity, 8'hFF);
    service(0, 0, 0, 30);
    checkOutput("midreset_pending_lost", w_entry_cycles + w_exit_cycles, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) bus.entry_req = ~bus.entry_req;
      if ($urandom_range(7) == 0) bus.exit_req = ~bus.exit_req;
      bus.exit_slot = 3'($urandom_range(7));
      bus.car_present = ($urandom_range(5) == 0);
      if ($urandom_range(999) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Sequences the entry and exit barriers of the car park and owns the slot-occupancy register.
- Exports the occupancy register as the 8-bit free-slot mask `parking_capacity` (bit = 1 means free), which downstream entry checking consumes.
- Buffers entry and exit requests and arbitrates between them.
- On entry, allocates the lowest-index free slot; on exit, releases the returned slot.
- Times each gate-open interval and extends it while a vehicle is under the gate.

Parameters:
- NUM_SLOTS, 8: number of parking slots; width of `parking_capacity`.
- SLOT_W, 3: slot index width; must equal ceil(log2(NUM_SLOTS)).
- GATE_CYCLES, 16: minimum gate-open time in clk cycles; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- entry_req  input  1  entry button/detector level; a rising edge is one request.
- exit_req  input  1  exit ticket level; a rising edge is one request.
- exit_slot  input  SLOT_W  slot being vacated; sampled on the exit_req rising edge.
- car_present  input  1  vehicle under whichever gate is currently open.
- entry_gate_open  output  1  entry barrier raised.
- exit_gate_open  output  1  exit barrier raised.
- grant_valid  output  1  one-cycle pulse: an entry was granted.
- grant_slot  output  SLOT_W  allocated slot; valid with grant_valid, held until the next grant.
- entry_denied  output  1  one-cycle pulse: entry refused because the car park is full.
- exit_error  output  1  one-cycle pulse: exit_slot was already free or out of range.
- parking_capacity  output  NUM_SLOTS  free-slot mask.
- free_count  output  SLOT_W+1  popcount of parking_capacity.
- full  output  1  free_count == 0.

Behaviour:
- Reset values (rst high at a clk edge):
  - parking_capacity = all ones; free_count = NUM_SLOTS; full = 0.
  - All gates and pulses = 0; grant_slot = 0.
  - Pending flags cleared; edge detectors loaded with 0.
  - FSM = IDLE; arbitration pointer = EXIT.
  - A reset mid-operation closes the gates on the next edge and discards pending requests.
- Request capture:
  - Registered edge detect on each request input.
  - A rising edge sets pend_entry or pend_exit. For exit, exit_slot is also latched into an exit_slot_q register.
  - A second rising edge while the flag is still pending is dropped; it is not queued.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, HOLD_ENTRY, HOLD_EXIT.
- IDLE, selecting a request:
  - With only one flag pending, that request is selected.
  - With both pending and full = 1, exit is selected.
  - With both pending and full = 0, the request opposite to the last one served is selected (round-robin).
- IDLE, servicing a selected entry:
  - If full, pulse entry_denied, clear pend_entry, stay in IDLE.
  - Otherwise, on the same edge: clear the lowest set bit of parking_capacity, load grant_slot with its index, pulse grant_valid, load the timer with GATE_CYCLES-1, go to ENTRY_OPEN.
- IDLE, servicing a selected exit:
  - If exit_slot_q ≥ NUM_SLOTS, or parking_capacity[exit_slot_q] is already 1, pulse exit_error, clear pend_exit, stay in IDLE.
  - Otherwise set that bit, load the timer, go to EXIT_OPEN.
- Pending flags, arbitration pointer and decision: the serviced request's pending flag clears on the decision edge. The arbitration pointer updates on every serviced request, including denied and erroneous ones.
- Open states (ENTRY_OPEN / EXIT_OPEN):
  - The corresponding gate output is 1; the timer decrements each cycle.
  - When the timer is 0: if car_present = 1, go to HOLD_x; otherwise close the gate and go to IDLE.
- HOLD_x: gate stays open until car_present = 0, then close and go to IDLE on that edge.
- Mutual exclusion: entry_gate_open and exit_gate_open are never 1 together.
- Latency:
  - Gate output rises 2 cycles after the request rising edge when no other request is in service: 1 cycle edge detect, 1 cycle decision.
  - Minimum open time is GATE_CYCLES cycles.
- Requests arriving during an open state stay pending and are serviced in IDLE afterwards. At least one IDLE cycle occurs between services.
- free_count and full are registered and consistent with parking_capacity in the same cycle.
- Allocation never wraps: the lowest free index always wins.
- All outputs are registered.

Test Plan:
- Reset, then an entry_req edge with car_present = 0:
  - grant_valid pulses with grant_slot = 0; parking_capacity = 8'hFE; free_count = 7.
  - entry_gate_open is high for exactly 16 cycles, then IDLE.
- Eight entries followed by a ninth:
  - Grants are slots 0..7; full = 1; parking_capacity = 8'h00.
  - The ninth entry produces entry_denied and no gate opening.
- Exit with exit_slot = 3 from the full state:
  - parking_capacity = 8'h08; exit_gate_open for 16 cycles.
  - A subsequent entry is granted slot 3.
- Exit with exit_slot = 5 while slot 5 is free:
  - exit_error pulses; parking_capacity and the gates are unchanged.
- Entry and exit edges in the same cycle:
  - When full, exit is serviced first, then entry.
  - When not full, service alternates starting from the exit side after reset.
  - The two gates never overlap.
- car_present held high at timer expiry for 5 cycles:
  - The gate stays open 5 extra cycles (HOLD), then closes.
- rst asserted during ENTRY_OPEN:
  - The gate closes on the next edge; parking_capacity = 8'hFF; pending requests are lost.
